// File: rtl/hovalaag_frame_assembler_if.sv
// Producer-to-assembler bus: phase-select/data slice in, assembled frame out.
// Handshake: no ready; a slice is accepted on a rising edge only when addr is the
// expected one-hot phase, and frame_valid pulses for the single cycle a frame lands.
interface hovalaag_frame_assembler_if;
  logic [9:0]  addr;
  logic [5:0]  io_in;
  logic [31:0] instr;
  logic [11:0] in1;
  logic [11:0] in2;
  logic        frame_valid;
  logic        sync_err;
  logic [7:0]  frame_count;
  logic        dbg_state;
  logic [3:0]  dbg_exp;

  modport master (
    output addr, io_in,
    input  instr, in1, in2, frame_valid, sync_err, frame_count, dbg_state, dbg_exp
  );

  modport slave (
    input  addr, io_in,
    output instr, in1, in2, frame_valid, sync_err, frame_count, dbg_state, dbg_exp
  );
endinterface

// File: rtl/hovalaag_frame_assembler.sv
// Assembles ten 6-bit phase slices into a 32-bit instruction and two 12-bit
// operands; outputs update atomically when phase 9 is captured.
module hovalaag_frame_assembler (
  input  logic                           clk,
  input  logic                           reset,
  hovalaag_frame_assembler_if.slave      bus
);
  typedef enum logic {HUNT = 1'b0, ASSEMBLE = 1'b1} state_t;

  state_t      state;
  logic [3:0]  exp;
  logic [31:0] shadow_instr;
  logic [11:0] shadow_in1;
  logic [11:0] shadow_in2;
  logic [9:0]  exp_onehot;

  assign exp_onehot    = 10'd1 << exp;
  assign bus.dbg_state = state;
  assign bus.dbg_exp   = exp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      exp             <= 4'd0;
      shadow_instr    <= 32'd0;
      shadow_in1      <= 12'd0;
      shadow_in2      <= 12'd0;
      bus.instr       <= 32'd0;
      bus.in1         <= 12'd0;
      bus.in2         <= 12'd0;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
      bus.frame_count <= 8'd0;
    end else begin
      bus.frame_valid <= 1'b0;
      case (state)
        HUNT: begin
          // Anything but a clean phase 0 is line noise while hunting, not an error.
          if (bus.addr == 10'd1) begin
            shadow_instr[5:0] <= bus.io_in;
            exp               <= 4'd1;
            state             <= ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (bus.addr == exp_onehot) begin
            case (exp)
              4'd1: shadow_instr[11:6]  <= bus.io_in;
              4'd2: shadow_instr[17:12] <= bus.io_in;
              4'd3: shadow_instr[23:18] <= bus.io_in;
              4'd4: shadow_instr[29:24] <= bus.io_in;
              4'd5: shadow_instr[31:30] <= bus.io_in[1:0];
              4'd6: shadow_in1[5:0]     <= bus.io_in;
              4'd7: shadow_in1[11:6]    <= bus.io_in;
              4'd8: shadow_in2[5:0]     <= bus.io_in;
              default: shadow_in2[11:6] <= bus.io_in;
            endcase
            if (exp == 4'd9) begin
              // The phase-9 slice bypasses the shadow so the frame lands this edge.
              bus.instr       <= shadow_instr;
              bus.in1         <= shadow_in1;
              bus.in2         <= {bus.io_in, shadow_in2[5:0]};
              bus.frame_valid <= 1'b1;
              bus.frame_count <= bus.frame_count + 8'd1;
              exp             <= 4'd0;
              state           <= HUNT;
            end else begin
              exp <= exp + 4'd1;
            end
          end else begin
            bus.sync_err <= 1'b1;
            shadow_in1   <= 12'd0;
            shadow_in2   <= 12'd0;
            if (bus.addr == 10'd1) begin
              shadow_instr <= {26'd0, bus.io_in};
              exp          <= 4'd1;
              state        <= ASSEMBLE;
            end else begin
              shadow_instr <= 32'd0;
              exp          <= 4'd0;
              state        <= HUNT;
            end
          end
        end
        default: begin
          exp   <= 4'd0;
          state <= HUNT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hovalaag_frame_assembler.sv
// Bench for hovalaag_frame_assembler: reference model of the phase protocol plus a
// queue of expected completed frames popped on every frame_valid pulse.
module tb_hovalaag_frame_assembler;
  logic clk;
  logic reset;
  hovalaag_frame_assembler_if bus ();

  hovalaag_frame_assembler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int n_pulses;

  // {instr, in1, in2, frame_count}
  logic [63:0] exp_q[$];

  // Reference model state
  logic        m_asm;
  int          m_exp;
  logic [31:0] m_si;
  logic [11:0] m_i1;
  logic [11:0] m_i2;
  logic [31:0] m_instr;
  logic [11:0] m_in1;
  logic [11:0] m_in2;
  logic [7:0]  m_count;
  logic        m_err;

  logic [5:0]  fd [10];

  task automatic model_reset();
    m_asm = 1'b0; m_exp = 0; m_si = '0; m_i1 = '0; m_i2 = '0;
    m_instr = '0; m_in1 = '0; m_in2 = '0; m_count = '0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input logic exp_fv, input string tag);
    logic [63:0] e;
    n_vec++;
    if (bus.frame_valid !== exp_fv) begin
      n_err++;
      $display("FAIL %s frame_valid: got %b want %b", tag, bus.frame_valid, exp_fv);
    end
    if (bus.frame_valid === 1'b1) begin
      n_pulses++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected frame: instr=%h", tag, bus.instr);
      end else begin
        e = exp_q.pop_front();
        if ({bus.instr, bus.in1, bus.in2, bus.frame_count} !== e) begin
          n_err++;
          $display("FAIL %s frame: got %h/%h/%h/%h want %h/%h/%h/%h", tag,
                   bus.instr, bus.in1, bus.in2, bus.frame_count,
                   e[63:32], e[31:20], e[19:8], e[7:0]);
        end
      end
    end
    n_vec++;
    if ({bus.instr, bus.in1, bus.in2, bus.frame_count, bus.sync_err} !==
        {m_instr, m_in1, m_in2, m_count, m_err}) begin
      n_err++;
      $display("FAIL %s outputs: got %h/%h/%h/%h err=%b want %h/%h/%h/%h err=%b", tag,
               bus.instr, bus.in1, bus.in2, bus.frame_count, bus.sync_err,
               m_instr, m_in1, m_in2, m_count, m_err);
    end
  endtask

  // One clock: drive on the falling edge, check 1ns after the rising edge.
  task automatic apply(input logic [9:0] a, input logic [5:0] d, input string tag);
    logic done;
    done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.addr = a;
    bus.io_in = d;
    if (!m_asm) begin
      if (a == 10'd1) begin
        m_si[5:0] = d; m_exp = 1; m_asm = 1'b1;
      end
    end else if (a == (10'd1 << m_exp)) begin
      case (m_exp)
        5: m_si[31:30] = d[1:0];
        6: m_i1[5:0] = d;
        7: m_i1[11:6] = d;
        8: m_i2[5:0] = d;
        9: m_i2[11:6] = d;
        default: m_si[6*m_exp +: 6] = d;
      endcase
      if (m_exp == 9) begin
        done = 1'b1;
        m_instr = m_si; m_in1 = m_i1; m_in2 = m_i2;
        m_count = m_count + 8'd1;
        exp_q.push_back({m_instr, m_in1, m_in2, m_count});
        m_asm = 1'b0; m_exp = 0;
      end else begin
        m_exp++;
      end
    end else begin
      m_err = 1'b1;
      m_si = '0; m_i1 = '0; m_i2 = '0;
      if (a == 10'd1) begin
        m_si[5:0] = d; m_exp = 1; m_asm = 1'b1;
      end else begin
        m_asm = 1'b0; m_exp = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(done, tag);
  endtask

  task automatic run_frame(input string tag);
    for (int k = 0; k < 10; k++) apply(10'd1 << k, fd[k], tag);
  endtask

  task automatic rand_fd();
    for (int k = 0; k < 10; k++) fd[k] = 6'($urandom_range(0, 63));
  endtask

  task automatic do_reset(input logic [9:0] a, input string tag);
    @(negedge clk);
    reset = 1'b1;
    bus.addr = a;
    bus.io_in = 6'h3F;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs(1'b0, tag);
    n_vec++;
    if (bus.dbg_state !== 1'b0 || bus.dbg_exp !== 4'd0) begin
      n_err++;
      $display("FAIL %s state: got %b/%0d want 0/0", tag, bus.dbg_state, bus.dbg_exp);
    end
  endtask

  task automatic test_reset();
    do_reset(10'd0, "reset");
    do_reset(10'd1, "reset_hold");
  endtask

  task automatic test_hunt();
    apply(10'h004, 6'h11, "hunt_004");
    apply(10'h000, 6'h22, "hunt_000");
    apply(10'h300, 6'h33, "hunt_300");
    n_vec++;
    if (bus.dbg_state !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL hunt_idle: got state=%b err=%b want 0/0", bus.dbg_state, bus.sync_err);
    end
    rand_fd();
    run_frame("hunt_frame");
  endtask

  task automatic test_nominal();
    do_reset(10'd0, "nom_reset");
    fd = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3F, 6'h2A, 6'h15, 6'h3C, 6'h03};
    run_frame("nominal");
    n_vec++;
    if (bus.in1 !== 12'h56A || bus.in2 !== 12'h0FC || bus.frame_count !== 8'd1) begin
      n_err++;
      $display("FAIL nominal_consts: got in1=%h in2=%h cnt=%0d want 56a/0fc/1",
               bus.in1, bus.in2, bus.frame_count);
    end
    apply(10'd0, 6'h00, "nominal_after");
  endtask

  task automatic test_out_of_order();
    do_reset(10'd0, "ooo_reset");
    apply(10'h001, 6'h0A, "ooo_p0");
    apply(10'h002, 6'h0B, "ooo_p1");
    apply(10'h004, 6'h0C, "ooo_p2");
    apply(10'h010, 6'h0D, "ooo_p4");
    rand_fd();
    run_frame("ooo_clean");
    n_vec++;
    if (bus.sync_err !== 1'b1 || bus.frame_count !== 8'd1) begin
      n_err++;
      $display("FAIL ooo_sticky: got err=%b cnt=%0d want 1/1", bus.sync_err, bus.frame_count);
    end
  endtask

  task automatic test_error_restart();
    rand_fd();
    for (int k = 0; k < 4; k++) apply(10'd1 << k, fd[k], "rst_partial");
    apply(10'h001, 6'h2D, "restart_p0");
    for (int k = 1; k < 10; k++) apply(10'd1 << k, fd[k], "restart_rest");
    apply(10'h001, 6'h01, "multi_p0");
    apply(10'h006, 6'h02, "multi_hot");
    apply(10'h000, 6'h03, "zero_addr");
    rand_fd();
    run_frame("after_multi");
  endtask

  task automatic test_mid_reset();
    do_reset(10'd0, "mid_pre");
    rand_fd();
    for (int k = 0; k < 5; k++) apply(10'd1 << k, fd[k], "mid_partial");
    do_reset(10'h020, "mid_reset");
    rand_fd();
    run_frame("mid_frame");
    n_vec++;
    if (bus.frame_count !== 8'd1 || bus.sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL mid_final: got cnt=%0d err=%b want 1/0", bus.frame_count, bus.sync_err);
    end
  endtask

  task automatic test_back_to_back();
    int start_pulses;
    do_reset(10'd0, "b2b_reset");
    start_pulses = n_pulses;
    for (int f = 0; f < 256; f++) begin
      rand_fd();
      run_frame("b2b");
    end
    n_vec++;
    if (bus.frame_count !== 8'd0 || (n_pulses - start_pulses) != 256) begin
      n_err++;
      $display("FAIL b2b_wrap: got cnt=%0d pulses=%0d want 0/256",
               bus.frame_count, n_pulses - start_pulses);
    end
    apply(10'd0, 6'h00, "b2b_idle");
  endtask

  task automatic check_drained(input string tag);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drained: got %0d pending frames want 0", tag, exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_pulses = 0;
    reset = 1'b1;
    bus.addr = '0;
    bus.io_in = '0;
    model_reset();
    test_reset();
    test_hunt();
    check_drained("hunt");
    test_nominal();
    check_drained("nominal");
    test_out_of_order();
    test_error_restart();
    check_drained("error");
    test_mid_reset();
    check_drained("mid");
    test_back_to_back();
    check_drained("b2b");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
